// File: rtl/stage1_pkg.sv
// Shared constants and state encoding for stage-1 post-processing.
package stage1_pkg;

  localparam int N_NEURONS = 32;
  localparam int ACC_W     = 32;
  localparam int IDX_W     = 5;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

endpackage

// File: rtl/requant_unit.sv
// Combinational bias-add, arithmetic shift, ReLU and saturation of one neuron sum.
module requant_unit
  import stage1_pkg::*;
#(
  parameter int SHIFT    = 8,
  parameter int OUT_BITS = 16
) (
  input  logic [ACC_W-1:0] p,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] result
);

  localparam logic signed [ACC_W:0] SAT_MAX =
    (ACC_W+1)'((64'd1 << (OUT_BITS - 1)) - 64'd1);

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    // 33-bit sum of two sign-extended 32-bit values cannot overflow
    sum     = $signed({p[ACC_W-1], p}) + $signed({b[ACC_W-1], b});
    shifted = sum >>> SHIFT;
    if (shifted[ACC_W]) begin
      result = '0;
    end else if (shifted > SAT_MAX) begin
      result = SAT_MAX[ACC_W-1:0];
    end else begin
      result = shifted[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/relu_requant1.sv
// Captures 32 neuron sums and streams requantized results over valid/ready.
// Optional feature macro: RELU1_BIAS_EN (per-neuron bias add).
module relu_requant1
  import stage1_pkg::*;
#(
  parameter int N        = N_NEURONS,
  parameter int SHIFT    = 8,
  parameter int OUT_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [ACC_W-1:0] p0,  p1,  p2,  p3,  p4,  p5,  p6,  p7,
  input  logic [ACC_W-1:0] p8,  p9,  p10, p11, p12, p13, p14, p15,
  input  logic [ACC_W-1:0] p16, p17, p18, p19, p20, p21, p22, p23,
  input  logic [ACC_W-1:0] p24, p25, p26, p27, p28, p29, p30, p31,
  input  logic [ACC_W-1:0] b0,  b1,  b2,  b3,  b4,  b5,  b6,  b7,
  input  logic [ACC_W-1:0] b8,  b9,  b10, b11, b12, b13, b14, b15,
  input  logic [ACC_W-1:0] b16, b17, b18, b19, b20, b21, b22, b23,
  input  logic [ACC_W-1:0] b24, b25, b26, b27, b28, b29, b30, b31,
  output logic [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             done_next;
  logic             load;
  logic [ACC_W-1:0] p_in   [N];
  logic [ACC_W-1:0] p_bank [N];
  logic [ACC_W-1:0] bias_sel;
  logic [ACC_W-1:0] rq_data;

  assign p_in = '{p0,  p1,  p2,  p3,  p4,  p5,  p6,  p7,
                  p8,  p9,  p10, p11, p12, p13, p14, p15,
                  p16, p17, p18, p19, p20, p21, p22, p23,
                  p24, p25, p26, p27, p28, p29, p30, p31};

`ifdef RELU1_BIAS_EN
  logic [ACC_W-1:0] b_in   [N];
  logic [ACC_W-1:0] b_bank [N];

  assign b_in = '{b0,  b1,  b2,  b3,  b4,  b5,  b6,  b7,
                  b8,  b9,  b10, b11, b12, b13, b14, b15,
                  b16, b17, b18, b19, b20, b21, b22, b23,
                  b24, b25, b26, b27, b28, b29, b30, b31};

  always_ff @(posedge clk) begin
    if (rst) begin
      b_bank <= '{default: '0};
    end else if (load) begin
      b_bank <= b_in;
    end
  end

  assign bias_sel = b_bank[idx];
`else
  logic unused_bias;

  assign unused_bias = ^{b0,  b1,  b2,  b3,  b4,  b5,  b6,  b7,
                         b8,  b9,  b10, b11, b12, b13, b14, b15,
                         b16, b17, b18, b19, b20, b21, b22, b23,
                         b24, b25, b26, b27, b28, b29, b30, b31};
  assign bias_sel = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      p_bank <= '{default: '0};
    end else if (load) begin
      p_bank <= p_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    done_next  = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture) begin
          state_next = EMIT;
          idx_next   = '0;
          load       = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx == IDX_W'(N - 1)) begin
            state_next = IDLE;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  requant_unit #(
    .SHIFT    (SHIFT),
    .OUT_BITS (OUT_BITS)
  ) u_requant (
    .p      (p_bank[idx]),
    .b      (bias_sel),
    .result (rq_data)
  );

  // Valid depends on registered state only; out_data forced to 0 while idle
  always_comb begin
    out_valid = (state == EMIT);
    busy      = (state == EMIT);
    out_idx   = idx;
    out_data  = out_valid ? rq_data : '0;
  end

endmodule

// File: tb/tb_relu_requant1.sv
// Self-checking bench for relu_requant1 with a plain-arithmetic reference model.
module tb_relu_requant1;

  localparam int  SHIFT    = 8;
  localparam int  OUT_BITS = 16;
  localparam longint MAXO  = (64'sd1 <<< (OUT_BITS - 1)) - 1;
`ifdef RELU1_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] p  [32];
  logic [31:0] b  [32];
  logic [31:0] sp [32];
  logic [31:0] sb [32];
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_valid, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  relu_requant1 #(.N(32), .SHIFT(SHIFT), .OUT_BITS(OUT_BITS)) dut (
    .clk(clk), .rst(rst), .capture(capture),
    .p0(p[0]),   .p1(p[1]),   .p2(p[2]),   .p3(p[3]),   .p4(p[4]),   .p5(p[5]),
    .p6(p[6]),   .p7(p[7]),   .p8(p[8]),   .p9(p[9]),   .p10(p[10]), .p11(p[11]),
    .p12(p[12]), .p13(p[13]), .p14(p[14]), .p15(p[15]), .p16(p[16]), .p17(p[17]),
    .p18(p[18]), .p19(p[19]), .p20(p[20]), .p21(p[21]), .p22(p[22]), .p23(p[23]),
    .p24(p[24]), .p25(p[25]), .p26(p[26]), .p27(p[27]), .p28(p[28]), .p29(p[29]),
    .p30(p[30]), .p31(p[31]),
    .b0(b[0]),   .b1(b[1]),   .b2(b[2]),   .b3(b[3]),   .b4(b[4]),   .b5(b[5]),
    .b6(b[6]),   .b7(b[7]),   .b8(b[8]),   .b9(b[9]),   .b10(b[10]), .b11(b[11]),
    .b12(b[12]), .b13(b[13]), .b14(b[14]), .b15(b[15]), .b16(b[16]), .b17(b[17]),
    .b18(b[18]), .b19(b[19]), .b20(b[20]), .b21(b[21]), .b22(b[22]), .b23(b[23]),
    .b24(b[24]), .b25(b[25]), .b26(b[26]), .b27(b[27]), .b28(b[28]), .b29(b[29]),
    .b30(b[30]), .b31(b[31]),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  function automatic logic [31:0] model(input logic [31:0] pv, input logic [31:0] bv);
    longint s;
    longint t;
    s = longint'($signed(pv)) + (BIAS ? longint'($signed(bv)) : 64'sd0);
    t = s >>> SHIFT;
    if (t < 0) return 32'd0;
    if (t > MAXO) return MAXO[31:0];
    return t[31:0];
  endfunction

  task automatic randomize_inputs;
    for (int i = 0; i < 32; i++) begin
      p[i] = $urandom();
      b[i] = $urandom();
    end
  endtask

  // Called at a negedge in IDLE; returns at the following negedge with capture low.
  task automatic do_capture;
    capture = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sp[i] = p[i];
      sb[i] = b[i];
    end
    @(negedge clk);
    capture = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    randomize_inputs();
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (out_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bias_add;
    logic [31:0] lit;
    randomize_inputs();
    p[0] = 32'h300;      b[0] = 32'h100;
    p[1] = 32'hFFFFFC18; b[1] = 32'h0;
    p[2] = 32'h7FFFFFFF; b[2] = 32'h7FFFFFFF;
    p[3] = 32'h0;        b[3] = 32'h0;
    out_ready = 1'b1;
    do_capture();
    for (int k = 0; k < 32; k++) begin
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got=%b/%b want=1/1", k, out_valid, busy); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL stream_idx got=%0d want=%0d", out_idx, k); end
      checks++; if (out_data !== model(sp[k], sb[k])) begin errors++; $display("FAIL stream_data k=%0d got=%h want=%h", k, out_data, model(sp[k], sb[k])); end
      if (k < 4) begin
        lit = (k == 0) ? (BIAS ? 32'd4 : 32'd3) : (k == 2) ? 32'h7FFF : 32'd0;
        checks++; if (out_data !== lit) begin errors++; $display("FAIL directed_data k=%0d got=%h want=%h", k, out_data, lit); end
      end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL early_done k=%0d got=%b want=0", k, done); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b valid=%b want=1 valid=0", done, out_valid); end
    // capture in the done cycle must be accepted
    randomize_inputs();
    do_capture();
    checks++; if (out_valid !== 1'b1 || out_idx !== 5'd0) begin errors++; $display("FAIL capture_on_done valid=%b idx=%0d want=1 idx=0", out_valid, out_idx); end
    checks++; if (out_data !== model(sp[0], sb[0])) begin errors++; $display("FAIL capture_on_done_data got=%h want=%h", out_data, model(sp[0], sb[0])); end
    repeat (33) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_pass valid=%b done=%b want=0 0", out_valid, done); end
  endtask

  task automatic test_backpressure;
    int k = 0;
    int cyc = 0;
    int dones = 0;
    logic [31:0] prev_data = '0;
    logic prev_ready = 1'b1;
    randomize_inputs();
    out_ready = 1'b0;
    do_capture();
    while (k < 32 && cyc < 2000) begin
      cyc++;
      if (done === 1'b1) dones++;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid k=%0d got=%b want=1", k, out_valid); end
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL bp_idx got=%0d want=%0d", out_idx, k); end
      checks++; if (out_data !== model(sp[k], sb[k])) begin errors++; $display("FAIL bp_data k=%0d got=%h want=%h", k, out_data, model(sp[k], sb[k])); end
      if (!prev_ready) begin
        checks++; if (out_data !== prev_data) begin errors++; $display("FAIL bp_hold k=%0d got=%h want=%h", k, out_data, prev_data); end
      end
      prev_data  = out_data;
      out_ready  = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      prev_ready = out_ready;
      if (out_ready) k++;
      @(negedge clk);
    end
    checks++; if (k != 32) begin errors++; $display("FAIL bp_timeout transfers=%0d want=32", k); end
    checks++; if (dones != 0) begin errors++; $display("FAIL bp_early_done count=%0d want=0", dones); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b want=1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_done_once done=%b valid=%b want=0 0", done, out_valid); end
  endtask

  task automatic test_capture_while_busy;
    randomize_inputs();
    out_ready = 1'b1;
    do_capture();
    for (int k = 0; k < 32; k++) begin
      capture = 1'b0;
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL cwb_idx got=%0d want=%0d", out_idx, k); end
      checks++; if (out_data !== model(sp[k], sb[k])) begin errors++; $display("FAIL cwb_data k=%0d got=%h want=%h", k, out_data, model(sp[k], sb[k])); end
      if (k == 5) begin
        randomize_inputs();
        capture = 1'b1;
      end
      @(negedge clk);
    end
    capture = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL cwb_done got=%b want=1", done); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cwb_no_restart got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid_stream;
    randomize_inputs();
    out_ready = 1'b1;
    do_capture();
    repeat (10) @(negedge clk);
    checks++; if (out_idx !== 5'd10) begin errors++; $display("FAIL rms_idx10 got=%0d want=10", out_idx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rms_idle valid=%b busy=%b want=0 0", out_valid, busy); end
    checks++; if (out_idx !== 5'd0 || out_data !== 32'd0) begin errors++; $display("FAIL rms_outputs idx=%0d data=%h want=0 0", out_idx, out_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rms_done got=%b want=0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rms_done_late got=%b want=0", done); end
    // reset wins over capture in the same cycle
    rst = 1'b1;
    capture = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    capture = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_priority got=%b want=0", out_valid); end
    randomize_inputs();
    do_capture();
    for (int k = 0; k < 32; k++) begin
      checks++; if (out_idx !== 5'(k)) begin errors++; $display("FAIL fresh_idx got=%0d want=%0d", out_idx, k); end
      checks++; if (out_data !== model(sp[k], sb[k])) begin errors++; $display("FAIL fresh_data k=%0d got=%h want=%h", k, out_data, model(sp[k], sb[k])); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fresh_done got=%b want=1", done); end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_bias_add();
    test_backpressure();
    test_capture_while_busy();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/relu_requant1.md
# relu_requant1

Stage-1 post-processing block placed directly downstream of the stage-1 systolic MAC array. When the array finishes accumulating, this block captures all 32 32-bit neuron sums. For each sum it adds a per-neuron bias, arithmetic right-shifts, applies ReLU and saturates. It then streams the 32 results one per transfer, over a valid/ready handshake, to the stage-2 input buffer.

## Interface
Parameters:
- N, 32, number of neurons captured per pass (fixed by stage 1).
- SHIFT, 8, arithmetic right-shift amount applied after bias add.
- OUT_BITS, 16, signed saturation width; results clamp to 0 .. 2^(OUT_BITS-1)-1.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- capture  input  1  one-cycle pulse: p0..p31 are final and must be latched.
- p0 … p31  input  32 each  signed accumulator outputs of the MAC array.
- b0 … b31  input  32 each  signed per-neuron biases; must be stable while `capture` is high.
- out_data  output  32  requantized result, zero-extended from OUT_BITS.
- out_idx  output  5  neuron index of `out_data`.
- out_valid  output  1  `out_data` and `out_idx` are valid.
- out_ready  input  1  downstream accepts the current value.
- busy  output  1  a capture is being streamed.
- done  output  1  one-cycle pulse after the last (index 31) transfer.

## Operation
- States:
  - IDLE: `out_valid`=0, `busy`=0.
  - EMIT: `out_valid`=1, `busy`=1.
- IDLE → EMIT on `capture`=1 at a rising edge. On that edge the block latches all p and b into an N-entry bank and sets idx=0.
- EMIT, transfer (`out_valid` and `out_ready`) with idx<31: idx increments.
- EMIT, transfer with idx=31: go to IDLE, idx=0, `done`=1 for the following cycle.
- EMIT without transfer: hold. `out_data` and `out_idx` stay stable while `out_ready`=0.
- `capture` is ignored while in EMIT. The bank is not overwritten.
- `capture` in the cycle where `done`=1 (state is IDLE) is accepted normally.
- Arithmetic per element:
  - s = sext33(p) + sext33(b), 33-bit signed, no overflow possible.
  - t = s >>> SHIFT.
  - If t<0, result 0. If t > 2^(OUT_BITS-1)-1, result 2^(OUT_BITS-1)-1. Otherwise result t.
  - `out_data` = result zero-extended to 32 bits.
- `out_data` is computed combinationally from bank[idx] and holds no extra pipeline register.

## Timing
- Reset values: state IDLE, idx 0, `out_valid` 0, `busy` 0, `done` 0, `out_idx` 0, `out_data` 0. Bank entries are cleared to 0.
- `rst` mid-stream: on the next edge the block is in IDLE with all outputs at reset values. Remaining elements are dropped and `done` is not asserted.
- `rst` has priority over `capture` in the same cycle.
- Latency: first `out_valid` in the cycle after the capture edge. Minimum 32 cycles per pass with `out_ready` held high. `done` appears in cycle 33 after capture.
- No combinational path from `out_ready` to `out_valid`.

## Configuration
- `RELU1_BIAS_EN` defined: bias is added as described.
- `RELU1_BIAS_EN` undefined: b0..b31 ports remain but are ignored, bias storage is not built, and s = sext33(p).

## Structure
- Shared package `stage1_pkg`:
  - Constants: N_NEURONS=32, ACC_W=32, IDX_W=5.
  - State enum: IDLE, EMIT.
- Sub-module `requant_unit`: single combinational instance implementing bias-add, shift, ReLU and saturate on the bank entry selected by idx.

## Test plan
- Bias add: p0=0x300, b0=0x100, capture, `out_ready`=1 → idx 0 `out_data`=4. With `RELU1_BIAS_EN` undefined → 3.
- Negative sum: p1=-1000, b1=0 → idx 1 `out_data`=0.
- Saturation: p2=b2=0x7FFFFFFF → `out_data`=0x00007FFF. Also p=0, b=0 → 0.
- Backpressure: toggle `out_ready` pseudo-randomly → all 32 indices appear once, in order. Data holds while not ready. `done` pulses exactly once after idx 31.
- Capture while busy: second `capture` with new p values at idx 5 → streamed values stay from the first capture.
- Reset mid-stream: `rst` after 10 transfers → next cycle `out_valid`=0, `busy`=0, `out_idx`=0, no `done`. A fresh capture then streams from idx 0.
